// File: rtl/dram_responder.sv
// Byte-wide data-memory responder with fixed read latency and a host port for preload/dump.
// Optional ACCESS_COUNT_EN macro enables saturating processor read/write counters.
module dram_responder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 65536,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] din,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    input  logic              host_en,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_din,
    output logic [DATA_W-1:0] host_dout,
    output logic              host_valid,
    output logic              err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        HOST    = 2'd2
    } state_t;

    // DEPTH may equal 2**ADDR_W, so compare with one extra bit
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_r, state_nxt_s;
    logic [2:0]        lat_cnt_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              host_we_r;
    logic [ADDR_W-1:0] host_addr_r;
    logic [DATA_W-1:0] host_din_r;
    logic [DATA_W-1:0] dout_r, host_dout_r;
    logic              host_valid_r, busy_r, err_r;

    logic err_set_s, rd_start_s, rd_done_s, host_start_s, host_done_s, pwr_s;

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_nxt_s  = state_r;
        err_set_s    = 1'b0;
        rd_start_s   = 1'b0;
        rd_done_s    = 1'b0;
        host_start_s = 1'b0;
        host_done_s  = 1'b0;
        pwr_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (host_en) begin
                    host_start_s = 1'b1;
                    state_nxt_s  = HOST;
                    err_set_s    = read | write | ~in_range(host_addr);
                end else if (read) begin
                    rd_start_s  = 1'b1;
                    state_nxt_s = RD_WAIT;
                    err_set_s   = write | ~in_range(addr_in);
                end else if (write) begin
                    pwr_s     = in_range(addr_in);
                    err_set_s = ~in_range(addr_in);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_WAIT: begin
                err_set_s = read | write | host_en;
                if (lat_cnt_r == 3'd0) begin
                    rd_done_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RD_WAIT;
                end
            end
            HOST: begin
                host_done_s = 1'b1;
                state_nxt_s = IDLE;
                err_set_s   = read | write;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latency counter, latched request fields and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt_r    <= 3'd0;
            rd_addr_r    <= '0;
            host_we_r    <= 1'b0;
            host_addr_r  <= '0;
            host_din_r   <= '0;
            dout_r       <= '0;
            host_dout_r  <= '0;
            host_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            host_valid_r <= host_done_s;
            busy_r       <= (state_nxt_s != IDLE);
            err_r        <= err_r | err_set_s;
            if (rd_start_s) begin
                lat_cnt_r <= 3'(RD_LAT - 1);
                rd_addr_r <= addr_in;
            end else if (state_r == RD_WAIT && lat_cnt_r != 3'd0) begin
                lat_cnt_r <= lat_cnt_r - 3'd1;
            end
            if (host_start_s) begin
                host_we_r   <= host_we;
                host_addr_r <= host_addr;
                host_din_r  <= host_din;
            end
            if (rd_done_s) begin
                dout_r <= in_range(rd_addr_r) ? mem[rd_addr_r[IDX_W-1:0]] : '0;
            end
            if (host_done_s && !host_we_r) begin
                host_dout_r <= in_range(host_addr_r) ? mem[host_addr_r[IDX_W-1:0]] : '0;
            end
        end
    end

    // Array write port; processor and host writes never coincide (IDLE vs HOST)
    always_ff @(posedge clk) begin
        if (pwr_s) begin
            mem[addr_in[IDX_W-1:0]] <= din;
        end else if (host_done_s && host_we_r && in_range(host_addr_r)) begin
            mem[host_addr_r[IDX_W-1:0]] <= host_din_r;
        end
    end

    assign dout       = dout_r;
    assign host_dout  = host_dout_r;
    assign host_valid = host_valid_r;
    assign busy       = busy_r;
    assign err        = err_r;

`ifdef ACCESS_COUNT_EN
    logic [15:0] rd_count_r, wr_count_r;

    // Saturating processor access counters
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_r <= 16'h0000;
            wr_count_r <= 16'h0000;
        end else begin
            if (rd_done_s && rd_count_r != 16'hFFFF) begin
                rd_count_r <= rd_count_r + 16'h0001;
            end
            if (pwr_s && wr_count_r != 16'hFFFF) begin
                wr_count_r <= wr_count_r + 16'h0001;
            end
        end
    end

    assign rd_count = rd_count_r;
    assign wr_count = wr_count_r;
`else
    assign rd_count = 16'h0000;
    assign wr_count = 16'h0000;
`endif

endmodule
